// File: rtl/datamemory_ls.sv
`default_nettype none
// ============================================================================
//  Module   : datamemory_ls
//  Brief    : Byte-addressed RV32 data memory with a latency-configurable load
//             pipeline, full RV32I load/store widths at any legal offset, and
//             one-cycle fault reporting for misaligned or illegal accesses.
//  Revision : 1.0 - initial release
// ============================================================================
module datamemory_ls #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,   // only 32 is meaningful for RV32
    parameter int RD_LATENCY = 1     // 1..8 edges from accept to rd_valid
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [DM_ADDRESS-1:0] a,
    input  logic [DATA_W-1:0]     wd,
    input  logic [2:0]            Funct3,
    output logic [DATA_W-1:0]     rd,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  fault
);

    localparam int         c_WORDS    = 2 ** (DM_ADDRESS - 2);
    localparam logic [2:0] c_CNT_INIT = 3'(RD_LATENCY - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [2:0]              r_cnt;
    logic [2:0]              w_cnt_nxt;
    logic                    w_done;

    logic [DATA_W-1:0]       r_mem [c_WORDS];

    logic [DM_ADDRESS-3:0]   w_idx;
    logic                    w_accept;
    logic                    w_align_ok;
    logic                    w_f3_ok;
    logic                    w_legal;
    logic                    w_do_load;
    logic                    w_do_store;
    logic                    w_fault;
    logic [3:0]              w_be;
    logic [DATA_W-1:0]       w_wdata;

    logic [DATA_W-1:0]       r_word;
    logic [1:0]              r_off;
    logic [2:0]              r_f3;
    logic [DATA_W-1:0]       r_rd;
    logic                    r_rd_valid;
    logic                    r_fault;

    logic [7:0]              w_byte;
    logic [15:0]             w_half;
    logic [DATA_W-1:0]       w_ext;

    assign w_idx    = a[DM_ADDRESS-1:2];
    // Reset is folded in so nothing is accepted (and no store lands) while held.
    assign w_accept = (r_state == IDLE) && (MemRead || MemWrite) && !reset;

    // Legality decode: alignment from the size bits, allowed encodings by direction.
    always_comb begin
        w_align_ok = 1'b0;
        w_f3_ok    = 1'b0;
        case (Funct3[1:0])
            2'b00:   w_align_ok = 1'b1;
            2'b01:   w_align_ok = ~a[0];
            2'b10:   w_align_ok = (a[1:0] == 2'b00);
            default: w_align_ok = 1'b0;
        endcase
        if (MemRead) begin
            w_f3_ok = (Funct3 == 3'b000) || (Funct3 == 3'b001) || (Funct3 == 3'b010) ||
                      (Funct3 == 3'b100) || (Funct3 == 3'b101);
        end else begin
            w_f3_ok = (Funct3 == 3'b000) || (Funct3 == 3'b001) || (Funct3 == 3'b010);
        end
    end

    // MemRead has priority, so a simultaneous store is simply dropped.
    assign w_legal    = w_align_ok && w_f3_ok;
    assign w_do_load  = w_accept && MemRead && w_legal;
    assign w_do_store = w_accept && !MemRead && MemWrite && w_legal;
    assign w_fault    = w_accept && !w_legal;

    // Store lane enables and replicated data so every lane sees its bytes.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = wd;
        case (Funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << a[1:0];
                w_wdata = {4{wd[7:0]}};
            end
            2'b01: begin
                w_be    = a[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{wd[15:0]}};
            end
            2'b10: begin
                w_be    = 4'b1111;
                w_wdata = wd;
            end
            default: w_be = 4'b0000;
        endcase
    end

    // Storage array: byte-masked write, contents survive reset.
    always_ff @(posedge clk) begin
        if (w_do_store) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    // FSM state and latency counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // FSM next-state: count down in LOAD, complete when the counter hits zero.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_do_load) begin
                    w_state_nxt = LOAD;
                    w_cnt_nxt   = c_CNT_INIT;
                end
            end
            LOAD: begin
                if (r_cnt == 3'd0) begin
                    w_state_nxt = IDLE;
                    w_done      = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Lane extraction and sign/zero extension of the captured word.
    always_comb begin
        w_byte = r_word[{r_off, 3'b000} +: 8];
        w_half = r_word[{r_off[1], 4'b0000} +: 16];
        case (r_f3)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_ext = {24'd0, w_byte};
            3'b101:  w_ext = {16'd0, w_half};
            default: w_ext = r_word;
        endcase
    end

    // Load capture at accept, result/pulse registers at completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word     <= '0;
            r_off      <= 2'd0;
            r_f3       <= 3'd0;
            r_rd       <= '0;
            r_rd_valid <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_rd_valid <= w_done;
            r_fault    <= w_fault;
            if (w_do_load) begin
                r_word <= r_mem[w_idx];
                r_off  <= a[1:0];
                r_f3   <= Funct3;
            end
            if (w_done) begin
                r_rd <= w_ext;
            end
        end
    end

    assign rd       = r_rd;
    assign rd_valid = r_rd_valid;
    assign fault    = r_fault;
    assign busy     = (r_state == LOAD);

endmodule
`default_nettype wire

// File: tb/tb_datamemory_ls.sv
`default_nettype none
// ============================================================================
//  Module   : tb_datamemory_ls
//  Brief    : Directed self-checking bench for datamemory_ls, with one
//             instance at RD_LATENCY=1 and one at RD_LATENCY=3.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_datamemory_ls;

    logic        clk;
    logic        reset;

    logic        mr1, mw1, mr3, mw3;
    logic [8:0]  a1, a3;
    logic [31:0] wd1, wd3;
    logic [2:0]  f31, f33;
    logic [31:0] rd1, rd3;
    logic        rv1, rv3, busy1, busy3, fault1, fault3;

    int n_cmp;
    int n_err;

    datamemory_ls #(.DM_ADDRESS(9), .DATA_W(32), .RD_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .MemRead(mr1), .MemWrite(mw1), .a(a1), .wd(wd1),
        .Funct3(f31), .rd(rd1), .rd_valid(rv1), .busy(busy1), .fault(fault1)
    );

    datamemory_ls #(.DM_ADDRESS(9), .DATA_W(32), .RD_LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset), .MemRead(mr3), .MemWrite(mw3), .a(a3), .wd(wd3),
        .Funct3(f33), .rd(rd3), .rd_valid(rv3), .busy(busy3), .fault(fault3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Store on the latency-1 instance; returns in cycle 0 after the accept edge.
    task automatic store1(input logic [8:0] addr, input logic [31:0] data, input logic [2:0] f3);
        mr1 = 1'b0; mw1 = 1'b1; a1 = addr; wd1 = data; f31 = f3;
        tick();
        mw1 = 1'b0;
    endtask

    // Load on the latency-1 instance; returns in cycle 1 with observations.
    task automatic load1(input logic [8:0] addr, input logic [2:0] f3,
                         output logic [31:0] rdv, output logic busy0, output logic valid1);
        mr1 = 1'b1; mw1 = 1'b0; a1 = addr; f31 = f3;
        tick();
        mr1 = 1'b0;
        busy0 = busy1;
        tick();
        rdv = rd1;
        valid1 = rv1;
    endtask

    task automatic store3(input logic [8:0] addr, input logic [31:0] data);
        mr3 = 1'b0; mw3 = 1'b1; a3 = addr; wd3 = data; f33 = 3'b010;
        tick();
        mw3 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        n_cmp++;
        if ({rd1, rv1, busy1, fault1} !== 35'd0) begin
            n_err++;
            $display("FAIL reset_lat1: got rd=%h v=%b b=%b f=%b, expected all 0", rd1, rv1, busy1, fault1);
        end
        n_cmp++;
        if ({rd3, rv3, busy3, fault3} !== 35'd0) begin
            n_err++;
            $display("FAIL reset_lat3: got rd=%h v=%b b=%b f=%b, expected all 0", rd3, rv3, busy3, fault3);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_word();
        logic [31:0] r;
        logic b0, v1;
        store1(9'h010, 32'hDEADBEEF, 3'b010);
        n_cmp++;
        if (busy1 !== 1'b0 || fault1 !== 1'b0) begin
            n_err++;
            $display("FAIL sw_nostall: got busy=%b fault=%b, expected 0 0", busy1, fault1);
        end
        load1(9'h010, 3'b010, r, b0, v1);
        n_cmp++;
        if (b0 !== 1'b1) begin
            n_err++;
            $display("FAIL lw_busy_c0: got %b expected 1", b0);
        end
        n_cmp++;
        if (v1 !== 1'b1 || r !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL lw_c1: got valid=%b rd=%h, expected 1 deadbeef", v1, r);
        end
        n_cmp++;
        if (busy1 !== 1'b0) begin
            n_err++;
            $display("FAIL lw_busy_c1: got %b expected 0", busy1);
        end
        tick();
        n_cmp++;
        if (rv1 !== 1'b0 || rd1 !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL lw_c2_hold: got valid=%b rd=%h, expected 0 deadbeef", rv1, rd1);
        end
    endtask

    task automatic test_byte();
        logic [31:0] r;
        logic b0, v1;
        store1(9'h020, 32'h00000000, 3'b010);
        store1(9'h022, 32'h000000A5, 3'b000);
        load1(9'h020, 3'b010, r, b0, v1);
        n_cmp++;
        if (v1 !== 1'b1 || r !== 32'h00A50000) begin
            n_err++;
            $display("FAIL sb_lw: got valid=%b rd=%h, expected 1 00a50000", v1, r);
        end
        load1(9'h022, 3'b000, r, b0, v1);
        n_cmp++;
        if (r !== 32'hFFFFFFA5) begin
            n_err++;
            $display("FAIL lb: got %h expected ffffffa5", r);
        end
        load1(9'h022, 3'b100, r, b0, v1);
        n_cmp++;
        if (r !== 32'h000000A5) begin
            n_err++;
            $display("FAIL lbu: got %h expected 000000a5", r);
        end
    endtask

    task automatic test_half();
        logic [31:0] r;
        logic b0, v1;
        store1(9'h030, 32'h11111111, 3'b010);
        store1(9'h032, 32'h00008001, 3'b001);
        load1(9'h030, 3'b010, r, b0, v1);
        n_cmp++;
        if (r !== 32'h80011111) begin
            n_err++;
            $display("FAIL sh_lw: got %h expected 80011111", r);
        end
        load1(9'h032, 3'b001, r, b0, v1);
        n_cmp++;
        if (r !== 32'hFFFF8001) begin
            n_err++;
            $display("FAIL lh: got %h expected ffff8001", r);
        end
        load1(9'h032, 3'b101, r, b0, v1);
        n_cmp++;
        if (r !== 32'h00008001) begin
            n_err++;
            $display("FAIL lhu: got %h expected 00008001", r);
        end
        load1(9'h031, 3'b100, r, b0, v1);
        n_cmp++;
        if (r !== 32'h00000011) begin
            n_err++;
            $display("FAIL lbu_lane1: got %h expected 00000011", r);
        end
        load1(9'h030, 3'b101, r, b0, v1);
        n_cmp++;
        if (r !== 32'h00001111) begin
            n_err++;
            $display("FAIL lhu_low: got %h expected 00001111", r);
        end
    endtask

    task automatic test_both();
        logic [31:0] r;
        logic b0, v1;
        mr1 = 1'b1; mw1 = 1'b1; a1 = 9'h010; wd1 = 32'h0; f31 = 3'b010;
        tick();
        mr1 = 1'b0; mw1 = 1'b0;
        n_cmp++;
        if (busy1 !== 1'b1) begin
            n_err++;
            $display("FAIL both_busy: got %b expected 1", busy1);
        end
        tick();
        n_cmp++;
        if (rv1 !== 1'b1 || rd1 !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL both_load: got valid=%b rd=%h, expected 1 deadbeef", rv1, rd1);
        end
        load1(9'h010, 3'b010, r, b0, v1);
        n_cmp++;
        if (r !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL both_store_dropped: got %h expected deadbeef", r);
        end
    endtask

    task automatic test_fault();
        logic [31:0] r;
        logic b0, v1;
        store1(9'h000, 32'h12345678, 3'b010);
        // misaligned LW
        mr1 = 1'b1; mw1 = 1'b0; a1 = 9'h005; f31 = 3'b010;
        tick();
        mr1 = 1'b0;
        n_cmp++;
        if (fault1 !== 1'b1 || busy1 !== 1'b0 || rv1 !== 1'b0) begin
            n_err++;
            $display("FAIL lw_misalign_c0: got f=%b b=%b v=%b, expected 1 0 0", fault1, busy1, rv1);
        end
        tick();
        n_cmp++;
        if (fault1 !== 1'b0 || rv1 !== 1'b0 || rd1 !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL lw_misalign_c1: got f=%b v=%b rd=%h, expected 0 0 deadbeef", fault1, rv1, rd1);
        end
        // misaligned SH
        store1(9'h003, 32'h0000FFFF, 3'b001);
        n_cmp++;
        if (fault1 !== 1'b1 || busy1 !== 1'b0) begin
            n_err++;
            $display("FAIL sh_misalign_c0: got f=%b b=%b, expected 1 0", fault1, busy1);
        end
        tick();
        n_cmp++;
        if (fault1 !== 1'b0 || rv1 !== 1'b0) begin
            n_err++;
            $display("FAIL sh_misalign_c1: got f=%b v=%b, expected 0 0", fault1, rv1);
        end
        // store with an unsigned-load encoding
        store1(9'h030, 32'h00000000, 3'b100);
        n_cmp++;
        if (fault1 !== 1'b1 || busy1 !== 1'b0) begin
            n_err++;
            $display("FAIL st_f3_100: got f=%b b=%b, expected 1 0", fault1, busy1);
        end
        tick();
        load1(9'h000, 3'b010, r, b0, v1);
        n_cmp++;
        if (r !== 32'h12345678) begin
            n_err++;
            $display("FAIL sh_fault_mem: got %h expected 12345678", r);
        end
        load1(9'h030, 3'b010, r, b0, v1);
        n_cmp++;
        if (r !== 32'h80011111) begin
            n_err++;
            $display("FAIL st100_fault_mem: got %h expected 80011111", r);
        end
    endtask

    task automatic test_back_to_back_lat3();
        logic exp_b, exp_v;
        store3(9'h040, 32'hAAAA5555);
        store3(9'h044, 32'h0000BEEF);
        mr3 = 1'b1; a3 = 9'h040; f33 = 3'b010;
        tick();
        a3 = 9'h044;
        for (int c = 0; c < 8; c++) begin
            exp_b = (c <= 2) || (c >= 4 && c <= 6);
            exp_v = (c == 3) || (c == 7);
            n_cmp++;
            if (busy3 !== exp_b || rv3 !== exp_v) begin
                n_err++;
                $display("FAIL lat3_cycle%0d: got busy=%b valid=%b, expected %b %b", c, busy3, rv3, exp_b, exp_v);
            end
            if (c == 3) begin
                n_cmp++;
                if (rd3 !== 32'hAAAA5555) begin
                    n_err++;
                    $display("FAIL lat3_rd_first: got %h expected aaaa5555", rd3);
                end
            end
            if (c == 7) begin
                n_cmp++;
                if (rd3 !== 32'h0000BEEF) begin
                    n_err++;
                    $display("FAIL lat3_rd_second: got %h expected 0000beef", rd3);
                end
            end
            if (c == 4) mr3 = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset_mid_load();
        mr3 = 1'b1; a3 = 9'h040; f33 = 3'b010;
        tick();
        mr3 = 1'b0;
        tick();
        n_cmp++;
        if (busy3 !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_busy_pre: got %b expected 1", busy3);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (busy3 !== 1'b0 || rd3 !== 32'h0 || rv3 !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_immediate: got busy=%b rd=%h v=%b, expected 0 0 0", busy3, rd3, rv3);
        end
        tick();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_cmp++;
            if (rv3 !== 1'b0 || rd3 !== 32'h0) begin
                n_err++;
                $display("FAIL rstmid_after%0d: got v=%b rd=%h, expected 0 0", c, rv3, rd3);
            end
        end
        mr3 = 1'b1; a3 = 9'h040; f33 = 3'b010;
        tick();
        mr3 = 1'b0;
        tick();
        tick();
        tick();
        n_cmp++;
        if (rv3 !== 1'b1 || rd3 !== 32'hAAAA5555) begin
            n_err++;
            $display("FAIL rstmid_mem_kept: got v=%b rd=%h, expected 1 aaaa5555", rv3, rd3);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        mr1 = 1'b0; mw1 = 1'b0; a1 = '0; wd1 = '0; f31 = '0;
        mr3 = 1'b0; mw3 = 1'b0; a3 = '0; wd3 = '0; f33 = '0;
        tick();
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_both();
        test_fault();
        test_back_to_back_lat3();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/datamemory_ls.md
# datamemory_ls

Byte-addressed RV32 data memory with a latency-configurable load pipeline, full RV32I load/store width support (LB/LH/LW/LBU/LHU, SB/SH/SW) at any legal byte offset, and misalignment/illegal-width fault reporting. It sits between the ALU/control unit and the writeback stage. It replaces the single-cycle, lane-0-only data memory with a stateful unit that:

- signals load completion with `rd_valid`;
- stalls new requests with `busy`;
- rejects bad accesses with `fault`.

## Interface

- `DM_ADDRESS`, default 9: byte-address width. Storage is `2**(DM_ADDRESS-2)` 32-bit words.
- `DATA_W`, default 32: data width. Only 32 is legal.
- `RD_LATENCY`, default 1: edges from load accept to `rd_valid`. Legal range 1..8.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `MemRead` in 1: load request from the control unit.
- `MemWrite` in 1: store request from the control unit.
- `a` in DM_ADDRESS: byte address (ALU output LSBs).
- `wd` in DATA_W: store data; the active bytes are the LSBs.
- `Funct3` in 3: instruction bits 14:12, selecting width and signedness.
- `rd` out DATA_W: load result, sign- or zero-extended. Holds its value until the next load completes.
- `rd_valid` out 1: one-cycle pulse when `rd` is updated.
- `busy` out 1: a load is in flight; requests are ignored.
- `fault` out 1: one-cycle pulse for a misaligned or illegal request.

## Operation

- **FSM states.** IDLE, LOAD. A latency counter `cnt` (3 bits) runs in LOAD.
- **Accept.** A request is accepted at a rising edge when state is IDLE and `MemRead|MemWrite`. If both are high, `MemRead` wins and the store is dropped. Requests while `busy` are ignored and are not queued.
- **Legality.** `Funct3` 000/100 need no alignment. 001/101 require `a[0]==0`. 010 requires `a[1:0]==0`. Stores accept only 000/001/010. Loads accept 000/001/010/100/101. Every other combination is illegal.
- **Illegal request.** No memory write and no state change. `fault`=1 for the cycle after the accept edge. `rd` and `rd_valid` are unaffected.
- **Store.** The write commits at the accept edge and the FSM stays in IDLE. Byte enables and placement by width:
  - SB: `wd[7:0]` into lane `a[1:0]`.
  - SH: `wd[15:0]` into lanes {`a[1]`*2+1, `a[1]`*2}.
  - SW: all four lanes.
  - Unselected lanes are preserved.
- **Load.**
  - At the accept edge: capture word `a[DM_ADDRESS-1:2]`, `a[1:0]` and `Funct3`. Go to LOAD with `cnt`=RD_LATENCY-1.
  - Each further edge decrements `cnt`.
  - On the edge where `cnt`==0 in LOAD: `rd` gets the extracted and extended value, `rd_valid` is set, and the state returns to IDLE.
- **Extraction.** Byte is selected by `a[1:0]`, halfword by `a[1]`.
  - LB, LH: sign-extended.
  - LBU, LHU: zero-extended.
  - LW: the whole word.
- **Width rule.** The word index is `a[DM_ADDRESS-1:2]`. No wrap or out-of-range case exists.
- **Reset.**
  - Returns to IDLE and clears `cnt`.
  - Output reset values: `rd`=0, `rd_valid`=0, `busy`=0, `fault`=0.
  - Memory contents are not cleared.
  - Reset during LOAD aborts the load: no `rd_valid` and `rd` stays 0.

## Timing

- Edge 0 is the accept edge; cycle n is the period after edge n.
- **Load.**
  - `busy`=1 in cycles 0..RD_LATENCY-1.
  - `rd_valid`=1 and the new `rd` appear in cycle RD_LATENCY only.
  - `busy`=0 in cycle RD_LATENCY. The next request is accepted at edge RD_LATENCY+1.
  - Throughput is one load per RD_LATENCY+1 cycles.
- **Store.** Zero stall. Back-to-back stores are accepted every edge.
- **Store then load.** A load accepted at edge 1 after a store at edge 0 to the same word returns the stored data (write-first).
- **Fault.** `fault` is high in cycle 0 only; `busy` is never asserted for a faulting request.
- **Output registers.** `rd_valid`, `busy` and `fault` are registered. `busy` is decoded from state.

## Test plan

- Reset, then SW `a`=0x010 `wd`=0xDEADBEEF, then LW `a`=0x010 with RD_LATENCY=1 -> `busy` high in cycle 0; `rd_valid` pulse in cycle 1; `rd`=0xDEADBEEF.
- SW 0x00000000 at 0x020, then SB `a`=0x022 `wd`=0x000000A5, then LW 0x020 -> `rd`=0x00A50000. Then LB 0x022 -> 0xFFFFFFA5; LBU 0x022 -> 0x000000A5.
- SH `a`=0x032 `wd`=0x00008001 over 0x11111111, then LW -> 0x80011111. Then LH 0x032 -> 0xFFFF8001; LHU 0x032 -> 0x00008001.
- LW `a`=0x005; SH `a`=0x003; store with `Funct3`=100 -> each gives a one-cycle `fault`, no `rd_valid`, no `busy`, memory unchanged on readback.
- RD_LATENCY=3: LW accepted at edge 0, with a second LW held asserted during cycles 0..2 ->
  - `busy` in cycles 0-2;
  - `rd_valid` only in cycle 3;
  - the second LW is accepted at edge 4, with `rd_valid` in cycle 7.
- RD_LATENCY=3: assert `reset` in cycle 1 of a load -> immediate `busy`=0 and `rd`=0; no `rd_valid` afterwards; memory contents retained.
